// File: rtl/echo_receiver.sv
// echo_receiver: converts the high time of an ultrasonic echo into a range in centimetres.
// Define ECHO_GLITCH_FILTER_EN to add an 8-cycle level filter behind the echo synchroniser.
module echo_receiver #(
  parameter int CLKS_PER_US = 100,
  parameter int US_PER_CM   = 58,
  parameter int TIMEOUT_US  = 38000,
  parameter int WIDTH       = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             echo,
  output logic [WIDTH-1:0] distance,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int SUB_W = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam int US_W  = $clog2(TIMEOUT_US + 1);

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLKS_PER_US - 1);
  localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(US_PER_CM - 1);
  localparam logic [US_W-1:0]  US_LIMIT = US_W'(TIMEOUT_US);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE,
    REPORT
  } state_t;

  state_t state, stateNext;

  logic             echoMeta, echoSync, echoS, echoPrev;
  logic             echoRise, echoFall;
  logic             counting, usTick, usLimit;
  logic [PRE_W-1:0] prescaler;
  logic [US_W-1:0]  usCnt;
  logic [SUB_W-1:0] subCnt;
  logic [WIDTH-1:0] cmCnt;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echoMeta <= 1'b0;
      echoSync <= 1'b0;
    end else begin
      echoMeta <= echo;
      echoSync <= echoMeta;
    end
  end

`ifdef ECHO_GLITCH_FILTER_EN
  logic       echoFilt;
  logic [2:0] filtCnt;

  // A new level is accepted only on its 8th consecutive cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echoFilt <= 1'b0;
      filtCnt  <= 3'd0;
    end else if (echoSync == echoFilt) begin
      filtCnt <= 3'd0;
    end else if (filtCnt == 3'd7) begin
      echoFilt <= echoSync;
      filtCnt  <= 3'd0;
    end else begin
      filtCnt <= filtCnt + 3'd1;
    end
  end

  assign echoS = echoFilt;
`else
  assign echoS = echoSync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) echoPrev <= 1'b0;
    else        echoPrev <= echoS;
  end

  assign echoRise = echoS & ~echoPrev;
  assign echoFall = ~echoS & echoPrev;
  assign counting = (state == WAIT_RISE) || (state == MEASURE);
  assign usTick   = counting && (prescaler == PRE_MAX);
  assign usLimit  = (usCnt == US_LIMIT);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves it unassigned, which would infer a latch.
  always_comb begin
    stateNext = state;
    timeout   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) stateNext = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (usLimit) begin
          timeout   = 1'b1;
          stateNext = IDLE;
        end else if (echoRise) begin
          stateNext = MEASURE;
        end
      end
      MEASURE: begin
        if (echoFall) begin
          stateNext = REPORT;
        end else if (usLimit) begin
          timeout   = 1'b1;
          stateNext = IDLE;
        end
      end
      REPORT: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // The microsecond timebase runs on through the WAIT_RISE->MEASURE transition,
  // so the timeout window spans both the wait and the measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      usCnt     <= '0;
      subCnt    <= '0;
      cmCnt     <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        prescaler <= '0;
        usCnt     <= '0;
        subCnt    <= '0;
        cmCnt     <= '0;
      end
    end else if (counting) begin
      prescaler <= usTick ? '0 : prescaler + 1'b1;
      if (usTick) usCnt <= usCnt + 1'b1;
      if (usTick && state == MEASURE) begin
        if (subCnt == SUB_MAX) begin
          subCnt <= '0;
          if (cmCnt != '1) cmCnt <= cmCnt + 1'b1;
        end else begin
          subCnt <= subCnt + 1'b1;
        end
      end
    end
  end

  // REPORT latches the final count; valid rises together with the new distance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      distance <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= (state == REPORT);
      if (state == REPORT) distance <= cmCnt;
    end
  end

endmodule
